arith_sequencer: RTL and testbench

- Sequences the four-PE arithmetic stage for one vector instruction at a time.
- Accepts a decoded arithmetic request from the issue logic and breaks it into 128-bit beats.
- For each beat it drives the stage's `cycle_count`, `elements_to_write`, `operand_select`, `op` and modes, and raises writeback valid.
- Handles reductions (ripple mode, single final write) and stalls when writeback back-pressures.

---
 rtl/arith_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_arith_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_sequencer.sv
// Beat sequencer for the four-PE arithmetic stage: turns one decoded vector
// arithmetic request into 128-bit beats and drives the stage's controls and writeback valid.
package arith_sequencer_pkg;
    typedef enum logic [3:0] {
        PE_ADD = 4'd0, PE_SUB = 4'd1, PE_AND = 4'd2, PE_OR  = 4'd3,
        PE_XOR = 4'd4, PE_MIN = 4'd5, PE_MAX = 4'd6, PE_MUL = 4'd7
    } pe_arith_op_t;

    typedef enum logic [1:0] {
        PE_OPERAND_VS1    = 2'd0,
        PE_OPERAND_SCALAR = 2'd1,
        PE_OPERAND_IMM    = 2'd2,
        PE_OPERAND_RIPPLE = 2'd3
    } pe_operand_t;

    typedef enum logic [1:0] {
        PE_SAT_NONE = 2'd0, PE_SAT_SIGNED = 2'd1, PE_SAT_UNSIGNED = 2'd2
    } pe_saturate_mode_t;

    typedef enum logic [1:0] {
        PE_OUT_NORMAL = 2'd0, PE_OUT_NARROW = 2'd1, PE_OUT_WIDEN = 2'd2
    } pe_output_mode_t;
endpackage

module arith_sequencer
    import arith_sequencer_pkg::*;
#(
    parameter int MAX_BEATS = 4
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_vl,
    input  logic [1:0]        req_vsew,
    input  pe_arith_op_t      req_op,
    input  pe_operand_t       req_operand,
    input  pe_saturate_mode_t req_sat,
    input  pe_output_mode_t   req_out,
    output logic [1:0]        cycle_count,
    output logic [1:0]        elements_to_write,
    output pe_operand_t       operand_select,
    output pe_arith_op_t      op,
    output pe_saturate_mode_t saturation_mode,
    output pe_output_mode_t   output_mode,
    output logic              wb_valid,
    output logic              wb_last,
    input  logic              wb_ready,
    output logic              busy,
    output logic              done
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [4:0] VL_MAX  = 5'(MAX_BEATS * 4);

    logic [1:0]        state_q, state_d;
    logic [1:0]        cycle_count_q, cycle_count_d;
    logic [1:0]        etw_q, etw_d;
    pe_operand_t       operand_q, operand_d;
    pe_arith_op_t      op_q, op_d;
    pe_saturate_mode_t sat_q, sat_d;
    pe_output_mode_t   out_q, out_d;
    logic              wb_valid_q, wb_valid_d;
    logic              wb_last_q, wb_last_d;
    logic              done_q, done_d;
    logic              ripple_q, ripple_d;
    logic [1:0]        last_beat_q, last_beat_d;
    logic [1:0]        last_etw_q, last_etw_d;

    // Beat geometry of the incoming request, all ceilings done as shift + round-up bit.
    logic [4:0] vl_clamp;
    logic [6:0] req_bytes;
    logic [4:0] req_lanes;
    logic [2:0] req_beats;
    logic       req_ripple;
    logic       req_zero;
    logic [1:0] req_last_beat;
    logic [1:0] req_last_etw;

    always_comb begin
        vl_clamp      = (req_vl > VL_MAX) ? VL_MAX : req_vl;
        req_bytes     = {2'b00, vl_clamp} << req_vsew;
        req_lanes     = req_bytes[6:2] + {4'b0000, |req_bytes[1:0]};
        req_ripple    = (req_operand == PE_OPERAND_RIPPLE);
        req_beats     = req_ripple ? (vl_clamp[4:2] + {2'b00, |vl_clamp[1:0]})
                                   : (req_lanes[4:2] + {2'b00, |req_lanes[1:0]});
        req_zero      = (req_vsew == 2'd3) || (req_beats == 3'd0);
        req_last_beat = req_beats[1:0] - 2'd1;
        req_last_etw  = req_ripple ? 2'd1 : req_lanes[1:0];
    end

    logic       at_last;
    logic       advance;
    logic [1:0] next_beat;
    logic       next_is_last;

    always_comb begin
        state_d       = state_q;
        cycle_count_d = cycle_count_q;
        etw_d         = etw_q;
        operand_d     = operand_q;
        op_d          = op_q;
        sat_d         = sat_q;
        out_d         = out_q;
        wb_valid_d    = wb_valid_q;
        wb_last_d     = wb_last_q;
        done_d        = 1'b0;
        ripple_d      = ripple_q;
        last_beat_d   = last_beat_q;
        last_etw_d    = last_etw_q;

        // Reduction beats before the last one carry no write, so they never wait on writeback.
        at_last      = (cycle_count_q == last_beat_q);
        advance      = wb_ready || (ripple_q && !at_last);
        next_beat    = cycle_count_q + 2'd1;
        next_is_last = (next_beat == last_beat_q);

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    operand_d     = req_operand;
                    op_d          = req_op;
                    sat_d         = req_sat;
                    out_d         = req_out;
                    ripple_d      = req_ripple;
                    last_beat_d   = req_last_beat;
                    last_etw_d    = req_last_etw;
                    cycle_count_d = 2'd0;
                    if (req_zero) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = ST_EXEC;
                        wb_last_d  = (req_last_beat == 2'd0);
                        wb_valid_d = !req_ripple || (req_last_beat == 2'd0);
                        etw_d      = (req_last_beat == 2'd0) ? req_last_etw : 2'd0;
                    end
                end
            end
            ST_EXEC: begin
                if (advance) begin
                    if (at_last) begin
                        state_d       = ST_DONE;
                        done_d        = 1'b1;
                        cycle_count_d = 2'd0;
                        wb_valid_d    = 1'b0;
                        wb_last_d     = 1'b0;
                        etw_d         = 2'd0;
                    end else begin
                        cycle_count_d = next_beat;
                        wb_valid_d    = !ripple_q || next_is_last;
                        wb_last_d     = next_is_last;
                        etw_d         = next_is_last ? last_etw_q : 2'd0;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q       <= ST_IDLE;
            cycle_count_q <= 2'd0;
            etw_q         <= 2'd0;
            operand_q     <= PE_OPERAND_VS1;
            op_q          <= PE_ADD;
            sat_q         <= PE_SAT_NONE;
            out_q         <= PE_OUT_NORMAL;
            wb_valid_q    <= 1'b0;
            wb_last_q     <= 1'b0;
            done_q        <= 1'b0;
            ripple_q      <= 1'b0;
            last_beat_q   <= 2'd0;
            last_etw_q    <= 2'd0;
        end else begin
            state_q       <= state_d;
            cycle_count_q <= cycle_count_d;
            etw_q         <= etw_d;
            operand_q     <= operand_d;
            op_q          <= op_d;
            sat_q         <= sat_d;
            out_q         <= out_d;
            wb_valid_q    <= wb_valid_d;
            wb_last_q     <= wb_last_d;
            done_q        <= done_d;
            ripple_q      <= ripple_d;
            last_beat_q   <= last_beat_d;
            last_etw_q    <= last_etw_d;
        end
    end

    assign req_ready         = (state_q == ST_IDLE);
    assign busy              = (state_q != ST_IDLE);
    assign cycle_count       = cycle_count_q;
    assign elements_to_write = etw_q;
    assign operand_select    = operand_q;
    assign op                = op_q;
    assign saturation_mode   = sat_q;
    assign output_mode       = out_q;
    assign wb_valid          = wb_valid_q;
    assign wb_last           = wb_last_q;
    assign done              = done_q;
endmodule

// File: tb/tb_arith_sequencer.sv
// Randomized bench for arith_sequencer: each request is checked against a
// beat list computed from vl/vsew arithmetic, plus stall stability and timing checks.
module tb_arith_sequencer;
    import arith_sequencer_pkg::*;

    logic              clk = 1'b0;
    logic              n_reset;
    logic              req_valid;
    logic              req_ready;
    logic [4:0]        req_vl;
    logic [1:0]        req_vsew;
    pe_arith_op_t      req_op;
    pe_operand_t       req_operand;
    pe_saturate_mode_t req_sat;
    pe_output_mode_t   req_out;
    logic [1:0]        cycle_count;
    logic [1:0]        elements_to_write;
    pe_operand_t       operand_select;
    pe_arith_op_t      op;
    pe_saturate_mode_t saturation_mode;
    pe_output_mode_t   output_mode;
    logic              wb_valid;
    logic              wb_last;
    logic              wb_ready;
    logic              busy;
    logic              done;

    typedef struct packed {
        logic [1:0] cc;
        logic [1:0] etw;
        logic       last;
        logic [3:0] opc;
        logic [1:0] opnd;
        logic [1:0] sat;
        logic [1:0] outm;
    } wr_t;

    int n_cmp = 0;
    int n_mis = 0;

    arith_sequencer #(.MAX_BEATS(4)) dut (
        .clk(clk), .n_reset(n_reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_vl(req_vl), .req_vsew(req_vsew), .req_op(req_op),
        .req_operand(req_operand), .req_sat(req_sat), .req_out(req_out),
        .cycle_count(cycle_count), .elements_to_write(elements_to_write),
        .operand_select(operand_select), .op(op),
        .saturation_mode(saturation_mode), .output_mode(output_mode),
        .wb_valid(wb_valid), .wb_last(wb_last), .wb_ready(wb_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] snap();
        return {14'd0, done, busy, wb_last, wb_valid, output_mode, saturation_mode,
                op, operand_select, elements_to_write, cycle_count};
    endfunction

    // mode 0: always ready, 1: random ready, 2: three-cycle stall on beat 1, 3: ready only when valid
    task automatic run_req(input int vl, input int vsew, input bit rip, input int mode);
        wr_t   exp_q[$];
        wr_t   got_q[$];
        wr_t   base;
        wr_t   rec;
        int    ev, lanes, nb, exec_cyc, stalls, stab_err, bad_valid, done_cnt, scnt;
        bit    prev_stall, first, exp_first_valid;
        logic [31:0] prev_snap;

        ev    = (vsew == 3) ? 0 : ((vl > 16) ? 16 : vl);
        lanes = (ev * (1 << vsew) + 3) / 4;
        nb    = rip ? (ev + 3) / 4 : (lanes + 3) / 4;

        base      = '0;
        base.opc  = 4'($urandom_range(0, 7));
        base.opnd = rip ? 2'd3 : 2'($urandom_range(0, 2));
        base.sat  = 2'($urandom_range(0, 2));
        base.outm = 2'($urandom_range(0, 2));
        if (nb > 0) begin
            if (rip) begin
                rec = base; rec.cc = 2'(nb - 1); rec.etw = 2'd1; rec.last = 1'b1;
                exp_q.push_back(rec);
            end else begin
                for (int k = 0; k < nb; k++) begin
                    rec = base;
                    rec.cc   = 2'(k);
                    rec.etw  = (k == nb - 1) ? 2'(lanes % 4) : 2'd0;
                    rec.last = (k == nb - 1);
                    exp_q.push_back(rec);
                end
            end
        end
        exp_first_valid = (nb > 0) && (!rip || nb == 1);

        @(negedge clk);
        check("ready_idle", 32'(req_ready), 32'd1);
        req_valid   = 1'b1;
        req_vl      = 5'(vl);
        req_vsew    = 2'(vsew);
        req_op      = pe_arith_op_t'(base.opc);
        req_operand = pe_operand_t'(base.opnd);
        req_sat     = pe_saturate_mode_t'(base.sat);
        req_out     = pe_output_mode_t'(base.outm);
        wb_ready    = 1'b0;

        @(negedge clk);
        req_valid   = 1'b0;
        req_vl      = 5'($urandom_range(0, 31));
        req_vsew    = 2'($urandom_range(0, 3));
        req_op      = pe_arith_op_t'(4'($urandom_range(0, 7)));
        req_operand = pe_operand_t'(2'($urandom_range(0, 3)));

        exec_cyc = 0; stalls = 0; stab_err = 0; bad_valid = 0; done_cnt = 0; scnt = 0;
        prev_stall = 1'b0; first = 1'b1; prev_snap = '0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (first) begin
                check("first_valid", 32'(wb_valid), 32'(exp_first_valid));
                check("first_done", 32'(done), 32'(nb == 0));
                first = 1'b0;
            end
            if (done) begin
                done_cnt++;
                break;
            end
            if (!busy) break;
            exec_cyc++;
            case (mode)
                0: wb_ready = 1'b1;
                1: wb_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (wb_valid && cycle_count == 2'd1 && scnt < 3) begin
                        wb_ready = 1'b0; scnt++;
                    end else wb_ready = 1'b1;
                end
                default: wb_ready = wb_valid;
            endcase
            if (prev_stall && snap() !== prev_snap) stab_err++;
            if (wb_valid) begin
                if (rip && int'(cycle_count) != nb - 1) bad_valid++;
                if (wb_ready)
                    got_q.push_back(wr_t'({cycle_count, elements_to_write, wb_last, op,
                                           operand_select, saturation_mode, output_mode}));
                else
                    stalls++;
            end
            prev_stall = wb_valid && !wb_ready;
            prev_snap  = snap();
            @(negedge clk);
        end

        check("done_pulse", 32'(done_cnt), 32'd1);
        check("write_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check("write_beat", 32'(got_q[i]), 32'(exp_q[i]));
        check("exec_cycles", 32'(exec_cyc), 32'(nb + stalls));
        check("stall_stable", 32'(stab_err), 32'd0);
        check("valid_on_beat", 32'(bad_valid), 32'd0);
        if (done_cnt == 1) begin
            @(negedge clk);
            check("done_one_cycle", {30'd0, done, req_ready}, 32'd1);
        end
        wb_ready = 1'b0;
        $display("txn vl=%0d vsew=%0d ripple=%0d mode=%0d beats=%0d writes=%0d stalls=%0d",
                 vl, vsew, rip, mode, nb, got_q.size(), stalls);
    endtask

    initial begin
        int n;
        int vl_r, vsew_r;
        bit rip_r;

        n_reset     = 1'b0;
        req_valid   = 1'b1;
        req_vl      = 5'd4;
        req_vsew    = 2'd2;
        req_op      = PE_SUB;
        req_operand = PE_OPERAND_VS1;
        req_sat     = PE_SAT_NONE;
        req_out     = PE_OUT_NORMAL;
        wb_ready    = 1'b0;

        repeat (3) begin
            @(negedge clk);
            check("rst_ready", 32'(req_ready), 32'd1);
            check("rst_busy", 32'(busy), 32'd0);
        end
        req_valid = 1'b0;
        n_reset   = 1'b1;
        @(negedge clk);
        check("post_rst_outputs", snap(), 32'd0);
        check("post_rst_ready", 32'(req_ready), 32'd1);

        run_req(16, 2, 1'b0, 0);
        run_req(6, 2, 1'b0, 0);
        run_req(6, 1, 1'b0, 0);
        run_req(13, 2, 1'b1, 3);
        run_req(8, 2, 1'b0, 2);
        run_req(0, 2, 1'b0, 0);
        run_req(5, 3, 1'b0, 1);
        run_req(20, 2, 1'b0, 0);
        run_req(1, 0, 1'b0, 1);

        for (int t = 0; t < 40; t++) begin
            rip_r  = ($urandom_range(0, 3) == 0);
            vsew_r = rip_r ? 2 : (($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2)));
            vl_r   = int'($urandom_range(0, 18));
            run_req(vl_r, vsew_r, rip_r, int'($urandom_range(0, 3)));
        end

        // Abort a 4-beat op mid-flight and make sure the sequencer is usable afterwards.
        @(negedge clk);
        req_valid   = 1'b1;
        req_vl      = 5'd16;
        req_vsew    = 2'd2;
        req_operand = PE_OPERAND_VS1;
        req_op      = PE_MUL;
        @(negedge clk);
        req_valid = 1'b0;
        wb_ready  = 1'b1;
        n = 0;
        while (cycle_count != 2'd2 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("reach_beat2", 32'(cycle_count), 32'd2);
        n_reset = 1'b0;
        #1;
        check("abort_outputs", snap(), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        check("abort_no_done", 32'(done), 32'd0);
        n_reset  = 1'b1;
        wb_ready = 1'b0;
        $display("txn reset abort at beat 2");
        run_req(9, 2, 1'b0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
